// File: rtl/keypad_pkg.sv
// Shared types, key map and small helpers for the 4x4 keypad scanner.
package keypad_pkg;

  typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD, RELEASE} scan_state_t;

  localparam int unsigned N_ROWS = 4;
  localparam int unsigned N_COLS = 4;

  localparam logic [3:0] KEY_MAP [4][4] = '{
    '{4'h1, 4'h2, 4'h3, 4'hA},
    '{4'h4, 4'h5, 4'h6, 4'hB},
    '{4'h7, 4'h8, 4'h9, 4'hC},
    '{4'hE, 4'h0, 4'hF, 4'hD}
  };

  typedef struct packed {
    logic       hit;
    logic [1:0] idx;
  } col_hit_t;

  // Active-low one-hot row drive for a row index.
  function automatic logic [3:0] row_drive(input logic [1:0] idx);
    return ~(4'b0001 << idx);
  endfunction

  // Flags exactly one low column and reports its index; multi-press is not a hit.
  function automatic col_hit_t single_low(input logic [3:0] cols);
    col_hit_t    r;
    int unsigned n;
    r = '0;
    n = 0;
    for (int i = 0; i < 4; i++) begin
      if (!cols[i]) begin
        n     = n + 1;
        r.idx = 2'(i);
      end
    end
    r.hit = (n == 1);
    return r;
  endfunction

endpackage

// File: rtl/keypad_scanner_if.sv
// Row/column matrix lines and decoded key output of the keypad scanner.
interface keypad_scanner_if;
  logic [3:0] cols;
  logic [3:0] rows;
  logic       valid_input;
  logic [3:0] input_key;

  modport master (output cols, input rows, input valid_input, input input_key);
  modport slave  (input cols, output rows, output valid_input, output input_key);
endinterface

// File: rtl/keypad_key_lookup.sv
// Combinational (row, col) to hex key code decode.
module keypad_key_lookup
  import keypad_pkg::*;
(
  input  logic [1:0] row_idx_i,
  input  logic [1:0] col_idx_i,
  output logic [3:0] key_o
);

  assign key_o = KEY_MAP[row_idx_i][col_idx_i];

endmodule

// File: rtl/keypad_scanner.sv
// Row-scanning 4x4 keypad controller with press/release debounce and a
// one-cycle pulse per accepted key.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES   = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 3
) (
  input  logic              clk,
  input  logic              reset,
  keypad_scanner_if.slave   kp
);

  localparam int unsigned CNT_MAX = (SETTLE_CYCLES > DEBOUNCE_CYCLES) ? SETTLE_CYCLES
                                                                      : DEBOUNCE_CYCLES;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] DEB_LAST    = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_TOP     = CNT_W'(CNT_MAX);

  scan_state_t      state_q;
  logic [1:0]       row_idx_q;
  logic [1:0]       col_idx_q;
  logic [CNT_W-1:0] settle_cnt_q;
  logic [CNT_W-1:0] deb_cnt_q;
  logic [3:0]       rows_q;
  logic             valid_q;
  logic [3:0]       key_q;

  col_hit_t         hit_c;
  logic [3:0]       key_c;
  logic             key_low_c;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] x);
    return (x == CNT_TOP) ? x : x + CNT_W'(1);
  endfunction

  assign hit_c     = single_low(kp.cols);
  assign key_low_c = ~kp.cols[col_idx_q];

  keypad_key_lookup u_lookup (
    .row_idx_i (row_idx_q),
    .col_idx_i (col_idx_q),
    .key_o     (key_c)
  );

  // Scan/debounce FSM; row drive always tracks row_idx_q.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= SCAN;
      row_idx_q    <= 2'd0;
      col_idx_q    <= 2'd0;
      settle_cnt_q <= '0;
      deb_cnt_q    <= '0;
      rows_q       <= 4'b1110;
      valid_q      <= 1'b0;
      key_q        <= 4'h0;
    end else begin
      valid_q <= 1'b0;
      case (state_q)
        SCAN: begin
          if (settle_cnt_q < SETTLE_LAST) begin
            settle_cnt_q <= sat_inc(settle_cnt_q);
          end else begin
            settle_cnt_q <= '0;
            if (hit_c.hit) begin
              col_idx_q <= hit_c.idx;
              deb_cnt_q <= '0;
              state_q   <= DEBOUNCE;
            end else begin
              row_idx_q <= row_idx_q + 2'd1;
              rows_q    <= row_drive(row_idx_q + 2'd1);
            end
          end
        end

        DEBOUNCE: begin
          if (key_low_c) begin
            deb_cnt_q <= sat_inc(deb_cnt_q);
            if (deb_cnt_q == DEB_LAST) begin
              valid_q <= 1'b1;
              key_q   <= key_c;
              state_q <= HELD;
            end
          end else begin
            // Bounce: abandon this row and continue scanning from the next one.
            settle_cnt_q <= '0;
            row_idx_q    <= row_idx_q + 2'd1;
            rows_q       <= row_drive(row_idx_q + 2'd1);
            state_q      <= SCAN;
          end
        end

        HELD: begin
          if (!key_low_c) begin
            deb_cnt_q <= '0;
            state_q   <= RELEASE;
          end
        end

        RELEASE: begin
          if (!key_low_c) begin
            deb_cnt_q <= sat_inc(deb_cnt_q);
            if (deb_cnt_q == DEB_LAST) begin
              settle_cnt_q <= '0;
              row_idx_q    <= 2'd0;
              rows_q       <= row_drive(2'd0);
              state_q      <= SCAN;
            end
          end else begin
            state_q <= HELD;
          end
        end

        default: state_q <= SCAN;
      endcase
    end
  end

  assign kp.rows        = rows_q;
  assign kp.valid_input = valid_q;
  assign kp.input_key   = key_q;

endmodule
